// File: rtl/led_blink_driver_if.sv
// ============================================================================
// Module      : led_blink_driver_if
// Description : Request/status bundle between core control and the LED driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_blink_driver_if #(
    parameter int PEND_W = 4,
    parameter int CNT_W  = 16
);
    logic              ledBlink;
    logic              clr_ovf;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic [CNT_W-1:0]  blink_count;

    modport master (
        output ledBlink, clr_ovf,
        input  led, busy, pending, overflow, blink_count
    );

    modport slave (
        input  ledBlink, clr_ovf,
        output led, busy, pending, overflow, blink_count
    );
endinterface

`default_nettype wire

// File: rtl/led_blink_driver.sv
// ============================================================================
// Module      : led_blink_driver
// Description : Turns ledBlink request cycles into queued, fixed-length LED
//               pulses separated by a fixed dark gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_driver #(
    parameter int ON_CYCLES  = 1000000,
    parameter int OFF_CYCLES = 1000000,
    parameter int PEND_W     = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic         clk_div,
    input  wire logic         rst,
    led_blink_driver_if.slave bus
);

    localparam int C_MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PH_W         = $clog2(C_MAX_CYCLES) + 1;

    localparam logic [PH_W-1:0]   c_PHASE_ONE = PH_W'(1);
    localparam logic [PH_W-1:0]   c_ON_LAST   = PH_W'(ON_CYCLES);
    localparam logic [PH_W-1:0]   c_OFF_LAST  = PH_W'(OFF_CYCLES);
    localparam logic [PEND_W-1:0] c_PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] c_PMAX      = {PEND_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic              r_led;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_blinkCount;

    state_t            w_stateNext;
    logic [PH_W-1:0]   w_phaseNext;
    logic              w_dec;
    logic              w_done;
    logic              w_drop;
    logic              w_inc;
    logic [PEND_W-1:0] w_pendingNext;

    // Next-state logic; w_dec marks the cycle a queued blink is started.
    always_comb begin
        w_stateNext = r_state;
        w_phaseNext = r_phase;
        w_dec       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != '0) begin
                    w_stateNext = ST_ON;
                    w_phaseNext = c_PHASE_ONE;
                    w_dec       = 1'b1;
                end
            end
            ST_ON: begin
                if (r_phase == c_ON_LAST) begin
                    w_stateNext = ST_GAP;
                    w_phaseNext = c_PHASE_ONE;
                    w_done      = 1'b1;
                end else begin
                    w_phaseNext = r_phase + c_PHASE_ONE;
                end
            end
            ST_GAP: begin
                if (r_phase == c_OFF_LAST) begin
                    if (r_pending != '0) begin
                        w_stateNext = ST_ON;
                        w_phaseNext = c_PHASE_ONE;
                        w_dec       = 1'b1;
                    end else begin
                        w_stateNext = ST_IDLE;
                        w_phaseNext = '0;
                    end
                end else begin
                    w_phaseNext = r_phase + c_PHASE_ONE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_phaseNext = '0;
            end
        endcase
    end

    // A full queue still accepts a request in the cycle a slot is freed.
    always_comb begin
        w_drop        = bus.ledBlink & (r_pending == c_PMAX) & ~w_dec;
        w_inc         = bus.ledBlink & ~w_drop;
        w_pendingNext = r_pending;
        if (w_inc && !w_dec) begin
            w_pendingNext = r_pending + c_PEND_ONE;
        end else if (w_dec && !w_inc) begin
            w_pendingNext = r_pending - c_PEND_ONE;
        end
    end

    always_ff @(posedge clk_div) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_led        <= 1'b0;
            r_pending    <= '0;
            r_overflow   <= 1'b0;
            r_blinkCount <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_phase    <= w_phaseNext;
            r_led      <= (w_stateNext == ST_ON);
            r_pending  <= w_pendingNext;
            r_overflow <= w_drop | (r_overflow & ~bus.clr_ovf);
            if (w_done) begin
                r_blinkCount <= r_blinkCount + c_CNT_ONE;
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.busy        = (r_state != ST_IDLE) || (r_pending != '0);
    assign bus.pending     = r_pending;
    assign bus.overflow    = r_overflow;
    assign bus.blink_count = r_blinkCount;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_driver.sv
// ============================================================================
// Module      : tb_led_blink_driver
// Description : Directed self-checking bench for led_blink_driver (4 on/3 off).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blink_driver;

    localparam int ON_CYCLES  = 4;
    localparam int OFF_CYCLES = 3;
    localparam int PEND_W     = 2;
    localparam int CNT_W      = 4;
    localparam int PERIOD     = ON_CYCLES + OFF_CYCLES;

    logic clk_div = 1'b0;
    logic rst     = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    led_blink_driver_if #(.PEND_W(PEND_W), .CNT_W(CNT_W)) bus ();

    led_blink_driver #(
        .ON_CYCLES (ON_CYCLES),
        .OFF_CYCLES(OFF_CYCLES),
        .PEND_W    (PEND_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_div(clk_div),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_div = ~clk_div;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    // Expected led after edge e when n requests are queued from edge 0.
    function automatic logic exp_led(input int e, input int n);
        if (e < 1) return 1'b0;
        return ((e - 1) / PERIOD < n) && ((e - 1) % PERIOD < ON_CYCLES);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.ledBlink = 1'b0;
        bus.clr_ovf  = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ledBlink = 1'b1;
        bus.clr_ovf  = 1'b0;
        step();
        step();
        checks++; if (bus.led !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", bus.led); end
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.blink_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.blink_count); end
        rst = 1'b1;
        step();
        bus.ledBlink = 1'b0;
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("FAIL reset_release_pending got=%0d exp=1", bus.pending); end
    endtask

    task automatic test_single(input string tag);
        bus.ledBlink = 1'b1;
        step();
        bus.ledBlink = 1'b0;
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("FAIL %s_pending0 got=%0d exp=1", tag, bus.pending); end
        checks++; if (bus.led !== 1'b0) begin errors++; $display("FAIL %s_led0 got=%b exp=0", tag, bus.led); end
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (bus.led !== exp_led(e, 1)) begin
                errors++; $display("FAIL %s_led edge=%0d got=%b exp=%b", tag, e, bus.led, exp_led(e, 1));
            end
            if (e == 5) begin
                checks++; if (bus.blink_count !== 4'd1) begin errors++; $display("FAIL %s_count got=%0d exp=1", tag, bus.blink_count); end
            end
            if (e == 7) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy_gap got=%b exp=1", tag, bus.busy); end
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", tag, bus.busy); end
    endtask

    task automatic test_burst();
        logic [1:0] expPend [3] = '{2'd1, 2'd1, 2'd2};
        do_reset();
        for (int e = 0; e <= 22; e++) begin
            bus.ledBlink = (e <= 2);
            step();
            if (e <= 2) begin
                checks++; if (bus.pending !== expPend[e]) begin errors++; $display("FAIL burst_pending edge=%0d got=%0d exp=%0d", e, bus.pending, expPend[e]); end
            end
            checks++;
            if (bus.led !== exp_led(e, 3)) begin
                errors++; $display("FAIL burst_led edge=%0d got=%b exp=%b", e, bus.led, exp_led(e, 3));
            end
            if (e == 21) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy_last got=%b exp=1", bus.busy); end
            end
        end
        bus.ledBlink = 1'b0;
        checks++; if (bus.blink_count !== 4'd3) begin errors++; $display("FAIL burst_count got=%0d exp=3", bus.blink_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end got=%b exp=0", bus.busy); end
    endtask

    task automatic test_overflow();
        logic [1:0] expPend [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int e = 0; e <= 29; e++) begin
            bus.ledBlink = (e <= 4);
            step();
            if (e <= 4) begin
                checks++; if (bus.pending !== expPend[e]) begin errors++; $display("FAIL ovf_pending edge=%0d got=%0d exp=%0d", e, bus.pending, expPend[e]); end
                checks++; if (bus.overflow !== (e == 4)) begin errors++; $display("FAIL ovf_flag edge=%0d got=%b exp=%b", e, bus.overflow, (e == 4)); end
            end
            checks++;
            if (bus.led !== exp_led(e, 4)) begin
                errors++; $display("FAIL ovf_led edge=%0d got=%b exp=%b", e, bus.led, exp_led(e, 4));
            end
        end
        bus.ledBlink = 1'b0;
        checks++; if (bus.blink_count !== 4'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", bus.blink_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got=%b exp=0", bus.busy); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_ovf_clear();
        do_reset();
        for (int e = 0; e <= 8; e++) begin
            bus.ledBlink = (e <= 5) || (e == 8);
            bus.clr_ovf  = (e == 5) || (e == 6);
            step();
            if (e == 5) begin
                checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_with_drop got=%b exp=1", bus.overflow); end
            end
            if (e == 6) begin
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", bus.overflow); end
            end
            if (e == 8) begin
                checks++; if (bus.pending !== 2'd3) begin errors++; $display("FAIL full_dec_pending got=%0d exp=3", bus.pending); end
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_dec_overflow got=%b exp=0", bus.overflow); end
                checks++; if (bus.led !== 1'b1) begin errors++; $display("FAIL full_dec_led got=%b exp=1", bus.led); end
            end
        end
        bus.ledBlink = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic test_reset_mid_on();
        do_reset();
        for (int e = 0; e <= 2; e++) begin
            bus.ledBlink = 1'b1;
            step();
        end
        bus.ledBlink = 1'b0;
        checks++; if (bus.led !== 1'b1 || bus.pending !== 2'd2) begin
            errors++; $display("FAIL midon_setup led=%b pending=%0d exp led=1 pending=2", bus.led, bus.pending);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (bus.led !== 1'b0) begin errors++; $display("FAIL midon_led got=%b exp=0", bus.led); end
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL midon_pending got=%0d exp=0", bus.pending); end
        checks++; if (bus.blink_count !== 4'd0) begin errors++; $display("FAIL midon_count got=%0d exp=0", bus.blink_count); end
        test_single("after_midon");
    endtask

    initial begin
        bus.ledBlink = 1'b0;
        bus.clr_ovf  = 1'b0;
        test_reset();
        do_reset();
        test_single("single");
        test_burst();
        test_overflow();
        test_ovf_clear();
        test_reset_mid_on();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
- Downstream consumer of the core's `ledBlink` strobe, which the control decoder asserts for every cycle that a blink-opcode instruction executes.
- Converts each request cycle into one visible, fixed-length LED pulse followed by a fixed dark gap.
- Queues requests that arrive faster than they can be displayed, and reports queue overflow and the number of completed blinks.
- Instantiated beside the core at top level on the same `clk_div` domain; drives the board LED pin.

Parameters:
- ON_CYCLES, 1000000, LED-on duration per blink in clk_div cycles (>=1)
- OFF_CYCLES, 1000000, dark gap after each blink in clk_div cycles (>=1)
- PEND_W, 4, pending-request counter width; capacity PMAX = 2^PEND_W-1
- CNT_W, 16, completed-blink counter width

Ports:
- clk_div  in  1  system clock (same clock as the core)
- rst  in  1  synchronous reset, active-low
- ledBlink  in  1  blink request from core control; every high cycle = one request
- clr_ovf  in  1  clears sticky overflow flag
- led  out  1  registered LED drive
- busy  out  1  state!=IDLE or pending!=0
- pending  out  PEND_W  queued, not-yet-started blinks
- overflow  out  1  sticky: a request was dropped
- blink_count  out  CNT_W  completed blinks, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, clk_div; reset rst is synchronous and active-low. At any rising edge with rst=0: state=IDLE, phase counter=0, led=0, pending=0, overflow=0, blink_count=0, busy=0. Reset mid-blink aborts it; queued requests are discarded.
- Request sampling: level per cycle, no edge detect. ledBlink=1 for k consecutive cycles = k requests.
- FSM states: IDLE, ON, GAP. led is registered and equals 1 exactly while state=ON.
- IDLE: if pending!=0 at an edge -> ON; phase loads 1; pending decrements ("dec").
- ON: phase counts 1..ON_CYCLES. At the edge with phase==ON_CYCLES -> GAP, phase=1, blink_count+1.
- GAP: phase counts 1..OFF_CYCLES. At the edge with phase==OFF_CYCLES: if pending!=0 -> ON with dec (back-to-back, no IDLE cycle); else -> IDLE.
- Pending update per edge: inc = ledBlink & accepted; dec as defined above.
  - inc and dec together -> unchanged.
  - inc only -> +1.
  - dec only -> -1.
- Saturation: if pending==PMAX, ledBlink=1 and no dec in that cycle, the request is dropped and overflow sets. If a dec occurs in that cycle, the request is accepted and pending stays at PMAX.
- Latency: ledBlink high in cycle N (IDLE, pending=0) -> pending=1 after edge N -> led=1 from edge N+1 for exactly ON_CYCLES cycles.
- Blink period: ON_CYCLES+OFF_CYCLES cycles per blink when back-to-back.
- overflow: set has priority over clr_ovf in the same cycle; clr_ovf alone clears it at the next edge.
- busy: combinational from registered state and pending only.
- blink_count: wraps from 2^CNT_W-1 to 0 with no flag.
- Phase counter width: $clog2(max(ON_CYCLES,OFF_CYCLES))+1. No other arithmetic on inputs.

Test Plan:
All tests use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2 (PMAX=3), CNT_W=4.
- Reset: rst=0 for 2 edges with ledBlink=1 -> led=0, pending=0, overflow=0, busy=0, blink_count=0. After rst=1 (ledBlink kept 1), pending=1 after the first edge.
- Single request: ledBlink=1 for cycle 0 only -> pending=1 after edge0; led=1 after edges 1-4 (4 cycles); led=0 for 3 gap cycles; blink_count=1 after edge5; IDLE and busy=0 after edge8.
- Burst of 3: ledBlink=1 in cycles 0-2 -> pending goes 1,1,2; three 4-on/3-off pulses back-to-back with no IDLE between; blink_count=3; overflow=0.
- Overflow: ledBlink=1 in cycles 0-4 -> pending 1,1,2,3,3; the request at cycle 4 is dropped and overflow=1. Exactly 4 pulses follow; blink_count=4.
- Overflow clear: clr_ovf=1 in a cycle where a request is also dropped -> overflow stays 1. clr_ovf=1 alone next cycle -> overflow=0.
- Reset mid-ON with pending=2: rst=0 for 1 edge -> led=0, pending=0, blink_count=0. A new single request then reproduces the single-request timing exactly.
